// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generator, enable/drain state machine,
// frame-end capture with stop-bit checking, and a first-word-fall-through receive FIFO.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_en,
  input  logic [DIV_W-1:0]              cfg_div,
  output logic                          o_clk_rx,
  input  logic                          i_rx_done,
  input  logic                          i_rx_stop_bit,
  input  logic [7:0]                    i_rx_data,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  input  logic                          i_clr_err,
  output logic                          o_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {OFF, ARM, RUN, STOPPING} state_t;

  state_t           state;
  logic [DIV_W-1:0] tick_cnt;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       arm_cnt;
  logic [7:0]       stop_cnt;
  logic             rx_done_p1;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic tick, frame_end, live, full, pop, accept, wr, set_ferr, set_ovr;

  assign tick      = (state != OFF) && (tick_cnt == div_q);
  assign o_clk_rx  = tick;
  assign o_busy    = (state != OFF);
  assign frame_end = rx_done_p1 && !i_rx_done;
  assign live      = (state == RUN) || (state == STOPPING);
  assign full      = (o_count == FULL_CNT);
  assign o_valid   = (o_count != '0);
  assign pop       = o_valid && i_ready;
  assign accept    = frame_end && live;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign wr        = accept && i_rx_stop_bit && (!full || pop);
  assign set_ferr  = accept && !i_rx_stop_bit;
  assign set_ovr   = accept && i_rx_stop_bit && full && !pop;
  assign o_data    = o_valid ? mem[rd_ptr] : 8'h00;

  // Divisor is latched only at wrap so a cfg_div change never truncates a period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= OFF;
      tick_cnt <= '0;
      div_q    <= '0;
      arm_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      if (tick) begin
        tick_cnt <= '0;
        div_q    <= cfg_div;
      end else if (state != OFF) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      case (state)
        OFF: begin
          tick_cnt <= '0;
          div_q    <= cfg_div;
          arm_cnt  <= '0;
          if (cfg_en) state <= ARM;
        end
        ARM: begin
          if (!cfg_en) begin
            state    <= OFF;
            tick_cnt <= '0;
          end else if (tick) begin
            arm_cnt <= arm_cnt + 1'b1;
            if (arm_cnt == 4'd15) state <= RUN;
          end
        end
        RUN: begin
          stop_cnt <= '0;
          if (!cfg_en) state <= STOPPING;
        end
        STOPPING: begin
          if (cfg_en) begin
            state <= RUN;
          end else if (frame_end || (tick && stop_cnt == 8'd159)) begin
            state    <= OFF;
            tick_cnt <= '0;
          end else if (tick) begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_done_p1  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      rx_done_p1 <= i_rx_done;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
      // A new error in the clearing cycle keeps the flag set.
      o_frame_err <= set_ferr | (o_frame_err & ~i_clr_err);
      o_overrun   <= set_ovr  | (o_overrun   & ~i_clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= i_rx_data;
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based FIFO/flag model compared every
// cycle, plus directed checks of tick timing, state sequencing and reset values.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;

  logic clk = 1'b0, reset = 1'b0, cfg_en = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic clk_rx, rx_done = 1'b0, stop_bit = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [7:0] rx_data = '0, data;
  logic valid, ferr, ovr, busy;
  logic [$clog2(DEPTH):0] count;

  bit live = 1'b0;
  int nvec = 0, nerr = 0;

  byte unsigned m_q[$];
  bit m_ferr = 1'b0, m_ovr = 1'b0, m_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_div(cfg_div), .o_clk_rx(clk_rx),
    .i_rx_done(rx_done), .i_rx_stop_bit(stop_bit), .i_rx_data(rx_data),
    .o_data(data), .o_valid(valid), .i_ready(ready), .o_count(count),
    .o_frame_err(ferr), .o_overrun(ovr), .i_clr_err(clr), .o_busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] d, input logic sb, input int hi);
    rx_data = d; stop_bit = sb; rx_done = 1'b1;
    step(hi);
    rx_done = 1'b0;
    step(1);
  endtask

  task automatic pop1();
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask

  // Model: a frame end while the receiver is live either errors, queues, or overruns.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_ferr = 1'b0; m_ovr = 1'b0; m_prev = 1'b0;
    end else begin
      bit fe, sf, so;
      fe = m_prev && !rx_done;
      sf = 1'b0; so = 1'b0;
      if (ready && m_q.size() != 0) void'(m_q.pop_front());
      if (fe && live) begin
        if (!stop_bit)              sf = 1'b1;
        else if (m_q.size() < DEPTH) m_q.push_back(rx_data);
        else                         so = 1'b1;
      end
      m_ferr = sf | (m_ferr & !clr);
      m_ovr  = so | (m_ovr & !clr);
      m_prev = rx_done;
    end
  end

  always @(negedge clk) begin
    check("count", count, m_q.size());
    check("valid", valid, m_q.size() != 0);
    if (m_q.size() != 0) check("data", data, m_q[0]);
    check("frame_err", ferr, m_ferr);
    check("overrun", ovr, m_ovr);
  end

  initial begin
    int ticks;
    step(3);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_count", count, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    check("rst_busy", busy, 0);
    check("rst_clk_rx", clk_rx, 0);
    reset = 1'b1;
    step(2);

    frame(8'h99, 1'b1, 4);
    check("off_discard", count, 0);

    cfg_div = 16'd3; cfg_en = 1'b1;
    step(1);
    check("arm_busy", busy, 1);
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      ticks += int'(clk_rx);
    end
    check("tick_period4", ticks, 10);

    // Frame end on the 64th ARM cycle is still discarded; two cycles later it is taken.
    step(19);
    rx_data = 8'h55; stop_bit = 1'b1; rx_done = 1'b1;
    step(4);
    rx_done = 1'b0;
    step(1);
    check("arm_edge_discard", count, 0);
    live = 1'b1;
    rx_data = 8'h5A; rx_done = 1'b1;
    step(1);
    rx_done = 1'b0;
    step(1);
    check("run_first_count", count, 1);
    check("run_first_data", data, 8'h5A);
    pop1();

    frame(8'hA5, 1'b1, 32);
    check("a5_valid", valid, 1);
    check("a5_data", data, 8'hA5);
    check("a5_count", count, 1);
    pop1();
    check("a5_popped", valid, 0);

    frame(8'h3C, 1'b0, 5);
    check("ferr_set", ferr, 1);
    check("ferr_count", count, 0);
    clr = 1'b1; step(1); clr = 1'b0;
    check("ferr_clr", ferr, 0);

    rx_data = 8'hC3; stop_bit = 1'b0; rx_done = 1'b1;
    step(2);
    rx_done = 1'b0; clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("ferr_set_wins", ferr, 1);
    clr = 1'b1; step(1); clr = 1'b0;

    for (int b = 1; b <= 5; b++) frame(8'(b), 1'b1, 3);
    check("ovr_count", count, 4);
    check("ovr_flag", ovr, 1);
    for (int b = 1; b <= 4; b++) begin
      check("ovr_pop_data", data, b);
      pop1();
    end
    check("ovr_drained", valid, 0);
    clr = 1'b1; step(1); clr = 1'b0;
    check("ovr_clr", ovr, 0);

    for (int b = 16; b <= 19; b++) frame(8'(b), 1'b1, 3);
    rx_data = 8'h14; stop_bit = 1'b1; rx_done = 1'b1;
    step(2);
    rx_done = 1'b0; ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("full_wp_count", count, 4);
    check("full_wp_ovr", ovr, 0);
    for (int b = 17; b <= 20; b++) begin
      check("full_wp_data", data, b);
      pop1();
    end
    ready = 1'b1; step(3); ready = 1'b0;
    check("empty_pop_count", count, 0);
    check("empty_pop_valid", valid, 0);

    rx_data = 8'h7E; stop_bit = 1'b1; rx_done = 1'b1;
    step(3);
    cfg_en = 1'b0;
    step(1);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      ticks += int'(clk_rx);
    end
    check("stopping_ticks", ticks, 2);
    check("stopping_busy", busy, 1);
    rx_done = 1'b0;
    step(1);
    check("stop_frame_off", busy, 0);
    check("stop_frame_clk_rx", clk_rx, 0);
    check("stop_frame_data", data, 8'h7E);
    check("stop_frame_count", count, 1);
    live = 1'b0;
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      ticks += int'(clk_rx);
    end
    check("off_no_ticks", ticks, 0);

    cfg_en = 1'b1; step(10);
    check("arm_abort_pre", busy, 1);
    cfg_en = 1'b0; step(1);
    check("arm_abort", busy, 0);

    cfg_en = 1'b1; step(80);
    live = 1'b1;
    cfg_en = 1'b0; step(1);
    step(630);
    check("timeout_pre", busy, 1);
    step(20);
    check("timeout_off", busy, 0);
    live = 1'b0;
    check("retained_count", count, 1);
    check("retained_data", data, 8'h7E);

    cfg_en = 1'b1; step(80);
    live = 1'b1;
    frame(8'hE1, 1'b1, 3);
    frame(8'h00, 1'b0, 3);
    check("pre_reset_count", count, 2);
    check("pre_reset_ferr", ferr, 1);
    reset = 1'b0; live = 1'b0;
    #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_ferr", ferr, 0);
    check("mid_rst_ovr", ovr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_clk_rx", clk_rx, 0);
    cfg_en = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    check("post_rst_count", count, 0);
    check("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter DIV_W, default 16, baud divisor width.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 cfg_en  input  1  receiver enable.
REQ-006 cfg_div  input  DIV_W  oversample tick period minus 1, in clk cycles.
REQ-007 o_clk_rx  output  1  one-clk oversample tick (16x baud) to RX datapath.
REQ-008 i_rx_done  input  1  RX stop-state level (high for one stop-bit period).
REQ-009 i_rx_stop_bit  input  1  registered stop-bit sample from RX.
REQ-010 i_rx_data  input  8  received byte from RX.
REQ-011 o_data  output  8  FIFO head byte.
REQ-012 o_valid  output  1  FIFO non-empty.
REQ-013 i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
REQ-014 o_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 o_frame_err  output  1  sticky: a frame had stop bit 0.
REQ-016 o_overrun  output  1  sticky: a good frame arrived with FIFO full.
REQ-017 i_clr_err  input  1  one-cycle clear of both sticky flags.
REQ-018 o_busy  output  1  high in any state other than OFF.

Function
REQ-019 Tick generator: counter counts 0..cfg_div, o_clk_rx=1 for one clk when counter==cfg_div, then wraps to 0; cfg_div=0 gives tick every clk.
REQ-020 Tick counter held at 0 and o_clk_rx=0 in state OFF; cfg_div changes take effect at next wrap.
REQ-021 States: OFF, ARM, RUN, STOPPING.
REQ-022 OFF -> ARM when cfg_en=1.
REQ-023 ARM: count 16 ticks, then -> RUN; ARM -> OFF immediately if cfg_en=0.
REQ-024 RUN -> STOPPING when cfg_en=0.
REQ-025 STOPPING: ticks continue; -> OFF on frame-end event or after 160 ticks, whichever first; cfg_en=1 in STOPPING -> RUN.
REQ-026 Frame-end event = falling edge of i_rx_done (registered i_rx_done=1, current i_rx_done=0); i_rx_data and i_rx_stop_bit sampled that cycle.
REQ-027 Frame-end events in OFF or ARM SHALL be discarded with no flag change.
REQ-028 In RUN/STOPPING: stop bit 0 -> set o_frame_err, byte not written.
REQ-029 Stop bit 1 and FIFO not full -> byte written; stop bit 1 and FIFO full -> byte dropped, o_overrun set, FIFO unchanged.
REQ-030 FIFO first-word-fall-through: o_data=head entry whenever o_valid=1; write visible on o_valid/o_data the cycle after the frame-end event.
REQ-031 Simultaneous write and pop: both performed, o_count unchanged; pop with FIFO full in same cycle as write SHALL accept the write (no overrun).
REQ-032 i_ready with o_valid=0 SHALL be ignored; o_count never wraps below 0 or above FIFO_DEPTH.
REQ-033 Pointers wrap modulo FIFO_DEPTH.
REQ-034 i_clr_err coinciding with a new error event: the flag SHALL end set (set wins).
REQ-035 FIFO contents and flags retained across OFF; only reset clears them.

Reset
REQ-036 On reset low: state OFF, tick counter 0, o_clk_rx=0, FIFO pointers and o_count 0, o_valid=0, o_data=0, o_frame_err=0, o_overrun=0, o_busy=0, registered i_rx_done=0.
REQ-037 Reset asserted mid-operation SHALL abort any state immediately and discard FIFO contents.

Verification
REQ-038 cfg_div=3, cfg_en=1 -> o_clk_rx pulses every 4 clk; ARM lasts 64 clk then RUN.
REQ-039 RUN, i_rx_done high 32 clk then low with data 0xA5, stop 1 -> next cycle o_valid=1, o_data=0xA5, o_count=1; pop -> o_valid=0.
REQ-040 Frame with stop 0, data 0x3C -> o_frame_err=1, o_count unchanged; i_clr_err -> o_frame_err=0.
REQ-041 FIFO_DEPTH=4, five good frames 0x01..0x05 without pops -> o_count=4, o_overrun=1, pops return 0x01..0x04.
REQ-042 cfg_en dropped mid-frame -> STOPPING, ticks continue, frame 0x7E stored, then OFF with o_clk_rx=0; no frame -> OFF after 160 ticks.
REQ-043 Full FIFO, write and pop same cycle -> o_count stays 4, o_overrun stays 0; reset mid-RUN -> all outputs at REQ-036 values.
